// File: rtl/psram_pkg.sv
// psram_pkg -- shared types and constants for the PSRAM sequencing controller.
//
// Contents:
//   psram_state_t       controller states (IDLE, SETUP, ACCESS, RECOVER)
//   PSRAM_CNT_W         width of the shared phase timer (4 bits, waits 1..15)
//   PSRAM_*_DEF         default read/write strobe widths and recovery time
package psram_pkg;

    localparam int unsigned PSRAM_CNT_W        = 4;
    localparam int unsigned PSRAM_RD_WAIT_DEF  = 2;
    localparam int unsigned PSRAM_WR_WAIT_DEF  = 2;
    localparam int unsigned PSRAM_RECOVERY_DEF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } psram_state_t;

endpackage : psram_pkg

// File: rtl/psram_timer.sv
// psram_timer -- loadable 4-bit down-counter with a zero flag.
//
// One instance times both the ACCESS phase (strobe width) and the RECOVER
// phase (CE-high time). A load takes priority over a decrement, and the
// counter saturates at zero.
//
// Ports:
//   clk_i       in   system clock
//   reset_i     in   asynchronous active-high reset (counter -> 0)
//   load_i      in   load load_val_i on the next edge
//   load_val_i  in   PSRAM_CNT_W  value to load
//   dec_i       in   decrement on the next edge (ignored while zero)
//   zero_o      out  counter currently equals zero
module psram_timer
    import psram_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [PSRAM_CNT_W-1:0] load_val_i,
    input  logic                   dec_i,
    output logic                   zero_o
);

    logic [PSRAM_CNT_W-1:0] cnt_q;
    logic [PSRAM_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : psram_timer

// File: rtl/psram_ctrl.sv
// psram_ctrl -- turns one 16-bit Wishbone classic access into a timed
// asynchronous PSRAM cycle (IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE).
//
// Optional build macro: PSRAM_CTRL_POSTED_WRITE_EN
//   defined   : writes are acked in the SETUP cycle; the RAM cycle finishes
//               in the background and the RECOVER ack is suppressed.
//   undefined : every access is acked in its first RECOVER cycle.
//
// Parameters: RD_WAIT / WR_WAIT (OE / WE low cycles, 1..15),
//             RECOVERY (CE high cycles after each access, 1..15).
//
// Ports:
//   clk_i, reset_i             clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i        Wishbone classic controls (RAM-select qualified)
//   wb_adr_i[23:1], wb_sel_i   halfword address, byte lanes
//   wb_dat_i / wb_dat_o        write data / registered read data
//   wb_ack_o                   single-cycle acknowledge
//   ram_adr_o, ram_dat_o       registered RAM address / write data
//   ram_dat_i                  RAM read data
//   ram_dat_oe_o               drive enable for the top-level tristate
//   ram_ce_on/oe_on/we_on      active-low strobes (registered)
//   ram_sel_on                 active-low byte enables (registered)
//   ram_adv_on/clk_o/cre_o     tied low (asynchronous mode)
//   busy_o                     state is not IDLE
module psram_ctrl
    import psram_pkg::*;
#(
    parameter int unsigned RD_WAIT  = PSRAM_RD_WAIT_DEF,
    parameter int unsigned WR_WAIT  = PSRAM_WR_WAIT_DEF,
    parameter int unsigned RECOVERY = PSRAM_RECOVERY_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [22:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [22:0] ram_adr_o,
    output logic [15:0] ram_dat_o,
    input  logic [15:0] ram_dat_i,
    output logic        ram_dat_oe_o,
    output logic        ram_ce_on,
    output logic        ram_oe_on,
    output logic        ram_we_on,
    output logic [1:0]  ram_sel_on,
    output logic        ram_adv_on,
    output logic        ram_clk_o,
    output logic        ram_cre_o,
    output logic        busy_o
);

    localparam logic [PSRAM_CNT_W-1:0] RD_LOAD  = PSRAM_CNT_W'(RD_WAIT - 1);
    localparam logic [PSRAM_CNT_W-1:0] WR_LOAD  = PSRAM_CNT_W'(WR_WAIT - 1);
    localparam logic [PSRAM_CNT_W-1:0] REC_LOAD = PSRAM_CNT_W'(RECOVERY - 1);

    psram_state_t state_q, state_d;

    logic [22:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [1:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        abort_q, abort_d;      // master dropped cyc during this access
    logic        ack_q, ack_d;
    logic [15:0] rdat_q, rdat_d;
    logic        ce_q, ce_d;
    logic        oe_q, oe_d;
    logic        wen_q, wen_d;
    logic [1:0]  rsel_q, rsel_d;
    logic        dat_oe_q, dat_oe_d;

    logic                   tmr_load;
    logic [PSRAM_CNT_W-1:0] tmr_val;
    logic                   tmr_dec;
    logic                   tmr_zero;

    psram_timer u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state and next-output logic. The pin values are computed for the
    // state being entered so that every RAM pin comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        abort_d  = abort_q;
        ack_d    = 1'b0;
        rdat_d   = rdat_q;
        ce_d     = 1'b1;
        oe_d     = 1'b1;
        wen_d    = 1'b1;
        rsel_d   = 2'b11;
        dat_oe_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d    = wb_adr_i;
                    sel_d    = wb_sel_i;
                    we_d     = wb_we_i;
                    abort_d  = 1'b0;
                    if (wb_we_i) begin
                        wdat_d = wb_dat_i;
                    end
                    tmr_load = 1'b1;
                    tmr_val  = wb_we_i ? WR_LOAD : RD_LOAD;
                    state_d  = SETUP;
                    ce_d     = 1'b0;
                    rsel_d   = ~wb_sel_i;
                    dat_oe_d = wb_we_i;
`ifdef PSRAM_CTRL_POSTED_WRITE_EN
                    ack_d    = wb_we_i;
`endif
                end
            end

            SETUP: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                state_d  = ACCESS;
                ce_d     = 1'b0;
                rsel_d   = ~sel_q;
                dat_oe_d = we_q;
                oe_d     = we_q;
                wen_d    = ~we_q;
            end

            ACCESS: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (tmr_zero) begin
                    state_d  = RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = REC_LOAD;
                    // Write data is held one extra cycle past the WE edge.
                    dat_oe_d = we_q;
                    if (!we_q) begin
                        rdat_d = ram_dat_i;
                    end
`ifdef PSRAM_CTRL_POSTED_WRITE_EN
                    ack_d = wb_cyc_i && !abort_q && !we_q;
`else
                    ack_d = wb_cyc_i && !abort_q;
`endif
                end else begin
                    tmr_dec  = 1'b1;
                    ce_d     = 1'b0;
                    rsel_d   = ~sel_q;
                    dat_oe_d = we_q;
                    oe_d     = we_q;
                    wen_d    = ~we_q;
                end
            end

            RECOVER: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            abort_q  <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            wen_q    <= 1'b1;
            rsel_q   <= 2'b11;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            abort_q  <= abort_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            wen_q    <= wen_d;
            rsel_q   <= rsel_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign wb_dat_o     = rdat_q;
    assign wb_ack_o     = ack_q;
    assign ram_adr_o    = adr_q;
    assign ram_dat_o    = wdat_q;
    assign ram_dat_oe_o = dat_oe_q;
    assign ram_ce_on    = ce_q;
    assign ram_oe_on    = oe_q;
    assign ram_we_on    = wen_q;
    assign ram_sel_on   = rsel_q;
    assign ram_adv_on   = 1'b0;
    assign ram_clk_o    = 1'b0;
    assign ram_cre_o    = 1'b0;
    assign busy_o       = (state_q != IDLE);

endmodule : psram_ctrl
